buscador_amostra_pwm: RTL and testbench
=======================================

# buscador_amostra_pwm

- Downstream neighbour of the address-sequencing state machine.
- On each sample tick it takes the current 22-bit word address and combines it with a song index into a full memory address.
- It fetches one 8-bit sample from external memory over a four-phase req/ack handshake, then plays the sample through a glitch-free 8-bit PWM output.
- It also owns the song index, advancing it when the sequencer signals end of song.

## Interface
Parameters:
- NUM_MUSICAS, 4: number of songs; index wraps at NUM_MUSICAS-1.
- SONG_W, 2: song index width (ceil(log2(NUM_MUSICAS))).
- TIMEOUT, 255: max cycles in FETCH waiting for mem_ack.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- count  in  1  sample tick; one clk-cycle pulse at 3 kHz, same signal that enables the sequencer.
- endereco  in  22  current word address from sequencer.
- prox_musica  in  1  end-of-song level from sequencer.
- mem_data  in  8  memory read data; valid while mem_ack=1.
- mem_ack  in  1  memory acknowledge.
- mem_req  out  1  read request, four-phase.
- mem_addr  out  SONG_W+22  {musica_atual, endereco} latched at tick.
- musica_atual  out  SONG_W  current song index.
- pwm_out  out  1  audio PWM.
- underrun  out  1  one-cycle pulse: sample missed (tick while busy, or timeout).
- volume  in  2  right-shift amount; present only with VOLUME_EN.

## Operation
- FSM states: IDLE, FETCH, RELEASE.
- IDLE:
  - count=1 → latch mem_addr = {musica_atual, endereco} → FETCH.
- FETCH:
  - mem_req=1; timeout counter increments each cycle.
  - mem_ack=1 → sample_next <= mem_data → RELEASE.
  - Counter reaches TIMEOUT with no ack → underrun pulse, sample_next unchanged → RELEASE.
- RELEASE:
  - mem_req=0; wait for mem_ack=0 → IDLE.
  - If already low on entry, leave after one cycle.
- count=1 while in FETCH or RELEASE → underrun pulse; tick dropped, no queueing.
- Song index:
  - Rising edge of prox_musica (registered compare) → musica_atual+1.
  - From NUM_MUSICAS-1 it wraps to 0.
  - A level held for many cycles advances the index once.
- Tick and prox_musica rising edge on the same cycle: the address latches the pre-increment musica_atual.
- PWM:
  - 8-bit free-running counter.
  - pwm_out = (pwm_cnt < sample_ativa).
  - sample_ativa <= sample_next only when pwm_cnt wraps 255→0, so there are no mid-period glitches.
  - Sample 0 → constant 0. Sample 255 → high 255 of 256 cycles.
- Reset values, asserted asynchronously and taking effect mid-transaction:
  - state=IDLE, mem_req=0, mem_addr=0, musica_atual=0.
  - sample_next=sample_ativa=8'h80 (midscale silence).
  - pwm_cnt=0, underrun=0, timeout counter=0, prox edge register=0.
  - Any pending fetch is abandoned.

## Timing
- Tick on edge N → mem_req=1 and mem_addr valid after edge N+1. Address is stable for the whole transaction.
- mem_ack sampled at edge M → mem_req=0 after edge M; sample_next updated at edge M.
- Best-case tick-to-capture: 2 edges with zero-wait memory.
- New sample appears on pwm_out at the next pwm_cnt wrap, at most 256 cycles after capture.
- underrun asserts in the cycle after the causing edge, for exactly one cycle.
- A timeout with TIMEOUT=255 fires 255 cycles after entering FETCH.
- All outputs are registered except pwm_out, which is a compare of registers (glitch-tolerant by design).

## Configuration
- VOLUME_EN defined:
  - Port volume[1:0] exists.
  - Captured sample becomes (mem_data >> volume) + (8'h80 - (8'h80 >> volume)), which attenuates around midscale.
  - volume=0 is identity.
- VOLUME_EN undefined:
  - No volume port.
  - Captured sample = mem_data unchanged.

## Structure
- Shared package buscador_pkg:
  - FSM state typedef (IDLE/FETCH/RELEASE).
  - SAMPLE_W=8, WORD_ADDR_W=22.
  - Silence constant 8'h80.
- Sub-module pwm_8bit: counter, double-buffered duty register, wrap strobe.
- Top: FSM, timeout counter, song-index logic, optional volume scaling.

## Test plan
- Reset, idle 600 cycles:
  - pwm_out high 128/256 cycles; mem_req=0; musica_atual=0.
- Tick with endereco=22'h00ABCD, musica=0, memory acks after 3 cycles with 8'hC0:
  - mem_addr=24'h00ABCD.
  - req held 3 cycles, then released.
  - After the next wrap, pwm_out high 192/256.
- Memory never acks:
  - underrun pulses 255 cycles after FETCH entry.
  - Sample stays 8'h80.
  - FSM returns to IDLE once ack=0.
- Second tick 2 cycles after the first, during FETCH:
  - One underrun pulse; only one transaction occurs.
- prox_musica high for 10 cycles, four times:
  - musica_atual goes 1, 2, 3, 0.
  - A tick coincident with the first edge latches song 0.
- VOLUME_EN with volume=2, mem_data=8'hFF:
  - Captured sample = 8'h3F + 8'h60 = 8'h9F.

Source files
------------

// File: rtl/buscador_amostra_pwm_pkg.sv
// Shared types and constants for the sample fetcher / PWM player.
// State encodings are plain logic constants so older netlists keep the same codes.
package buscador_pkg;

  localparam int SAMPLE_W    = 8;
  localparam int WORD_ADDR_W = 22;

  localparam logic [SAMPLE_W-1:0] SILENCE = 8'h80;

  typedef logic [1:0] state_t;

  localparam state_t IDLE    = 2'd0;
  localparam state_t FETCH   = 2'd1;
  localparam state_t RELEASE = 2'd2;

endpackage

// File: rtl/buscador_amostra_pwm_if.sv
// Memory read bus: four-phase req/ack with the address held for the whole transaction.
// The master drives req/addr; the memory returns data/ack.
interface buscador_amostra_pwm_if #(
  parameter int SONG_W = 2
);
  localparam int ADDR_W = SONG_W + buscador_pkg::WORD_ADDR_W;

  logic                                mem_req;
  logic [ADDR_W-1:0]                   mem_addr;
  logic [buscador_pkg::SAMPLE_W-1:0]   mem_data;
  logic                                mem_ack;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_data,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_data,
    output mem_ack
  );

endinterface

// File: rtl/buscador_amostra_pwm_pwm_8bit.sv
// 8-bit PWM: free-running counter, duty reloaded only on the 255->0 wrap
// so a new sample never truncates or stretches a period already in progress.
module pwm_8bit
  import buscador_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] duty_i,
  output logic                pwm_o
);

  logic [SAMPLE_W-1:0] cnt_q;
  logic [SAMPLE_W-1:0] duty_q;
  logic                wrap;

  assign wrap = (cnt_q == 8'hFF);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      duty_q <= SILENCE;
    end else begin
      cnt_q <= cnt_q + 8'd1;
      if (wrap) duty_q <= duty_i;
    end
  end

  // Duty 0 never matches, duty 255 leaves only count 255 low.
  assign pwm_o = (cnt_q < duty_q);

endmodule

// File: rtl/buscador_amostra_pwm.sv
// Sample fetcher: on each tick reads one sample from memory and plays it via PWM.
// Optional VOLUME_EN macro adds a volume[1:0] port that attenuates around midscale.
module buscador_amostra_pwm
  import buscador_pkg::*;
#(
  parameter int NUM_MUSICAS = 4,
  parameter int SONG_W      = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   count,
  input  logic [WORD_ADDR_W-1:0] endereco,
  input  logic                   prox_musica,
  buscador_amostra_pwm_if.master mem,
  output logic [SONG_W-1:0]      musica_atual,
  output logic                   pwm_out,
  output logic                   underrun
`ifdef VOLUME_EN
  ,
  input  logic [1:0]             volume
`endif
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  state_t                          state_q,    state_d;
  logic [TO_W-1:0]                 to_cnt_q,   to_cnt_d;
  logic [SONG_W+WORD_ADDR_W-1:0]   addr_q,     addr_d;
  logic                            req_q,      req_d;
  logic [SAMPLE_W-1:0]             sample_q,   sample_d;
  logic [SONG_W-1:0]               musica_q,   musica_d;
  logic                            underrun_q, underrun_d;
  logic                            prox_q;
  logic                            prox_rise;
  logic [SAMPLE_W-1:0]             captured;

`ifdef VOLUME_EN
  // Shift toward zero, then re-centre so the midscale point stays at 8'h80.
  function automatic logic [SAMPLE_W-1:0] scale_volume(
    input logic [SAMPLE_W-1:0] s,
    input logic [1:0]          vol
  );
    return (s >> vol) + (SILENCE - (SILENCE >> vol));
  endfunction

  assign captured = scale_volume(mem.mem_data, volume);
`else
  assign captured = mem.mem_data;
`endif

  assign prox_rise = prox_musica & ~prox_q;

  always_comb begin
    state_d    = state_q;
    to_cnt_d   = to_cnt_q;
    addr_d     = addr_q;
    req_d      = req_q;
    sample_d   = sample_q;
    musica_d   = musica_q;
    underrun_d = 1'b0;

    if (prox_rise) begin
      musica_d = (musica_q == SONG_W'(NUM_MUSICAS - 1)) ? '0 : musica_q + 1'b1;
    end

    // Address uses musica_q, so a coincident song edge still reads the old song.
    case (state_q)
      IDLE: begin
        if (count) begin
          addr_d   = {musica_q, endereco};
          req_d    = 1'b1;
          to_cnt_d = '0;
          state_d  = FETCH;
        end
      end
      FETCH: begin
        if (count) underrun_d = 1'b1;
        if (mem.mem_ack) begin
          sample_d = captured;
          req_d    = 1'b0;
          state_d  = RELEASE;
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          underrun_d = 1'b1;
          req_d      = 1'b0;
          state_d    = RELEASE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        if (count) underrun_d = 1'b1;
        if (!mem.mem_ack) state_d = IDLE;
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      to_cnt_q   <= '0;
      addr_q     <= '0;
      req_q      <= 1'b0;
      sample_q   <= SILENCE;
      musica_q   <= '0;
      underrun_q <= 1'b0;
      prox_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      to_cnt_q   <= to_cnt_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      sample_q   <= sample_d;
      musica_q   <= musica_d;
      underrun_q <= underrun_d;
      prox_q     <= prox_musica;
    end
  end

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = addr_q;
  assign musica_atual = musica_q;
  assign underrun     = underrun_q;

  pwm_8bit u_pwm (
    .clk    (clk),
    .reset  (reset),
    .duty_i (sample_q),
    .pwm_o  (pwm_out)
  );

endmodule

// File: tb/tb_buscador_amostra_pwm.sv
// Directed bench for buscador_amostra_pwm: fetch handshake, timeout, dropped ticks,
// song index wrap, PWM duty, asynchronous reset and (with VOLUME_EN) volume scaling.
module tb_buscador_amostra_pwm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        count = 1'b0;
  logic [21:0] endereco = '0;
  logic        prox_musica = 1'b0;
  logic [1:0]  musica_atual;
  logic        pwm_out;
  logic        underrun;
`ifdef VOLUME_EN
  logic [1:0]  volume = 2'd0;
`endif

  int checks = 0;
  int errors = 0;

  buscador_amostra_pwm_if #(.SONG_W(2)) mif ();

  buscador_amostra_pwm #(
    .NUM_MUSICAS (4),
    .SONG_W      (2),
    .TIMEOUT     (255)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .count        (count),
    .endereco     (endereco),
    .prox_musica  (prox_musica),
    .mem          (mif),
    .musica_atual (musica_atual),
    .pwm_out      (pwm_out),
    .underrun     (underrun)
`ifdef VOLUME_EN
    ,
    .volume       (volume)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Caller is at a negedge; returns at the negedge after the tick edge.
  task automatic tick(input logic [21:0] a);
    count    = 1'b1;
    endereco = a;
    @(negedge clk);
    count    = 1'b0;
  endtask

  task automatic finish_fetch(input logic [7:0] d);
    bit released = 1'b0;
    mif.mem_data = d;
    mif.mem_ack  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!mif.mem_req) begin
        released = 1'b1;
        break;
      end
    end
    checks++;
    if (!released) begin
      errors++;
      $display("FAIL fetch_release: mem_req still %0b after 20 cycles, required 0", mif.mem_req);
    end
    mif.mem_ack = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic measure_pwm(output int highs);
    highs = 0;
    repeat (256) begin
      @(negedge clk);
      if (pwm_out) highs++;
    end
  endtask

  task automatic test_reset();
    int highs;
    bit saw_req = 1'b0;
    bit saw_und = 1'b0;
    mif.mem_ack  = 1'b0;
    mif.mem_data = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++;
    if (mif.mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b, required 0", mif.mem_req); end
    checks++;
    if (mif.mem_addr !== 24'h000000) begin errors++; $display("FAIL reset_addr: got %h, required 000000", mif.mem_addr); end
    checks++;
    if (musica_atual !== 2'd0) begin errors++; $display("FAIL reset_musica: got %0d, required 0", musica_atual); end
    checks++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %0b, required 0", underrun); end
    measure_pwm(highs);
    checks++;
    if (highs != 128) begin errors++; $display("FAIL reset_pwm_duty: got %0d/256 high, required 128", highs); end
    repeat (344) begin
      @(negedge clk);
      if (mif.mem_req) saw_req = 1'b1;
      if (underrun) saw_und = 1'b1;
    end
    checks++;
    if (saw_req || saw_und) begin errors++; $display("FAIL idle_quiet: req=%0b underrun=%0b seen, required 0 0", saw_req, saw_und); end
  endtask

  task automatic test_timeout();
    int k_hit = -1;
    int highs;
    tick(22'h3FFFFF);
    checks++;
    if (mif.mem_addr !== 24'h3FFFFF) begin errors++; $display("FAIL timeout_addr: got %h, required 3fffff", mif.mem_addr); end
    for (int k = 0; k < 400; k++) begin
      if (underrun) begin
        k_hit = k;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (k_hit != 255) begin errors++; $display("FAIL timeout_delay: underrun after %0d cycles, required 255", k_hit); end
    checks++;
    if (mif.mem_req !== 1'b0) begin errors++; $display("FAIL timeout_req_drop: got %0b, required 0", mif.mem_req); end
    // Hold ack high so the FSM is parked in RELEASE.
    mif.mem_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL timeout_pulse_width: got %0b, required 0", underrun); end
    repeat (255) @(negedge clk);
    measure_pwm(highs);
    checks++;
    if (highs != 128) begin errors++; $display("FAIL timeout_sample_kept: got %0d/256 high, required 128", highs); end
    tick(22'h000001);
    checks++;
    if (underrun !== 1'b1) begin errors++; $display("FAIL release_tick_underrun: got %0b, required 1", underrun); end
    mif.mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tick(22'h000002);
    checks++;
    if (mif.mem_req !== 1'b1 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL back_to_idle: req=%0b underrun=%0b, required 1 0", mif.mem_req, underrun);
    end
    finish_fetch(8'h80);
  endtask

  task automatic test_fetch();
    int highs;
    tick(22'h00ABCD);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mif.mem_req !== 1'b1 || mif.mem_addr !== 24'h00ABCD) begin
        errors++;
        $display("FAIL fetch_cycle%0d: req=%0b addr=%h, required 1 00abcd", i, mif.mem_req, mif.mem_addr);
      end
      if (i == 2) begin
        mif.mem_ack  = 1'b1;
        mif.mem_data = 8'hC0;
      end
      @(negedge clk);
    end
    checks++;
    if (mif.mem_req !== 1'b0) begin errors++; $display("FAIL fetch_req_release: got %0b, required 0", mif.mem_req); end
    mif.mem_ack  = 1'b0;
    mif.mem_data = 8'h00;
    @(negedge clk);
    checks++;
    if (mif.mem_addr !== 24'h00ABCD) begin errors++; $display("FAIL fetch_addr_stable: got %h, required 00abcd", mif.mem_addr); end
    repeat (256) @(negedge clk);
    measure_pwm(highs);
    checks++;
    if (highs != 192) begin errors++; $display("FAIL fetch_pwm_c0: got %0d/256 high, required 192", highs); end
  endtask

  task automatic test_extremes();
    int highs;
    tick(22'h000010);
    finish_fetch(8'hFF);
    repeat (256) @(negedge clk);
    measure_pwm(highs);
    checks++;
    if (highs != 255) begin errors++; $display("FAIL pwm_ff: got %0d/256 high, required 255", highs); end
    tick(22'h000011);
    finish_fetch(8'h00);
    repeat (256) @(negedge clk);
    measure_pwm(highs);
    checks++;
    if (highs != 0) begin errors++; $display("FAIL pwm_00: got %0d/256 high, required 0", highs); end
  endtask

  task automatic test_back_to_back();
    bit saw_req = 1'b0;
    tick(22'h000111);
    @(negedge clk);
    tick(22'h000222);
    checks++;
    if (underrun !== 1'b1 || mif.mem_req !== 1'b1) begin
      errors++;
      $display("FAIL b2b_underrun: underrun=%0b req=%0b, required 1 1", underrun, mif.mem_req);
    end
    checks++;
    if (mif.mem_addr !== 24'h000111) begin errors++; $display("FAIL b2b_addr: got %h, required 000111", mif.mem_addr); end
    @(negedge clk);
    checks++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL b2b_pulse_width: got %0b, required 0", underrun); end
    finish_fetch(8'h80);
    repeat (20) begin
      @(negedge clk);
      if (mif.mem_req) saw_req = 1'b1;
    end
    checks++;
    if (saw_req) begin errors++; $display("FAIL b2b_single_txn: req=1 seen after release, required 0"); end
  endtask

  task automatic test_song();
    logic [1:0] expected;
    for (int b = 0; b < 4; b++) begin
      for (int c = 0; c < 20; c++) begin
        prox_musica  = (c < 10);
        count        = (b == 0 && c == 0);
        endereco     = 22'h001234;
        mif.mem_ack  = mif.mem_req;
        mif.mem_data = 8'h80;
        @(negedge clk);
        if (b == 0 && c == 0) begin
          checks++;
          if (mif.mem_addr !== 24'h001234 || musica_atual !== 2'd1) begin
            errors++;
            $display("FAIL song_coincident: addr=%h musica=%0d, required 001234 1", mif.mem_addr, musica_atual);
          end
        end
      end
      expected = 2'(b + 1);
      checks++;
      if (musica_atual !== expected) begin errors++; $display("FAIL song_burst%0d: got %0d, required %0d", b, musica_atual, expected); end
    end
    count       = 1'b0;
    prox_musica = 1'b0;
    mif.mem_ack = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_async_reset();
    prox_musica = 1'b1;
    @(negedge clk);
    prox_musica = 1'b0;
    @(negedge clk);
    checks++;
    if (musica_atual !== 2'd1) begin errors++; $display("FAIL pre_reset_musica: got %0d, required 1", musica_atual); end
    tick(22'h000777);
    checks++;
    if (mif.mem_req !== 1'b1) begin errors++; $display("FAIL pre_reset_req: got %0b, required 1", mif.mem_req); end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (mif.mem_req !== 1'b0 || mif.mem_addr !== 24'h000000 || musica_atual !== 2'd0) begin
      errors++;
      $display("FAIL async_reset: req=%0b addr=%h musica=%0d, required 0 000000 0", mif.mem_req, mif.mem_addr, musica_atual);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (mif.mem_req !== 1'b0) begin errors++; $display("FAIL post_reset_idle: req=%0b, required 0", mif.mem_req); end
  endtask

`ifdef VOLUME_EN
  task automatic test_volume();
    int highs;
    volume = 2'd2;
    tick(22'h000020);
    finish_fetch(8'hFF);
    repeat (256) @(negedge clk);
    measure_pwm(highs);
    checks++;
    if (highs != 159) begin errors++; $display("FAIL volume2_ff: got %0d/256 high, required 159", highs); end
    volume = 2'd0;
    tick(22'h000021);
    finish_fetch(8'hC0);
    repeat (256) @(negedge clk);
    measure_pwm(highs);
    checks++;
    if (highs != 192) begin errors++; $display("FAIL volume0_identity: got %0d/256 high, required 192", highs); end
  endtask
`endif

  initial begin
    test_reset();
    test_timeout();
    test_fetch();
    test_extremes();
    test_back_to_back();
    test_song();
    test_async_reset();
`ifdef VOLUME_EN
    test_volume();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
